conv_out_wb_packer: RTL
=======================

# conv_out_wb_packer

Write-back packer directly downstream of the systolic conv MAC/accumulation stage. Takes the Tout-lane quantized conv output beats (`conv_out_dat_vld`/`conv_out_dat`), keeps the active low-order bits of each lane, packs 1/2/4 beats into one full-width memory word and queues words in a FIFO for the DDR write-back master. Since the conv pipeline has no backpressure, the block raises an early stall flag sized to cover the in-flight MAC latency.

## Interface
- TOUT, 32, output lanes per beat
- LANE_DW, 8, bits per lane on input (max BN output width)
- OUT_W, TOUT*LANE_DW (256), output word width
- FIFO_DEPTH, 16, word FIFO depth (power of 2)
- AFULL_MARGIN, 6, free entries reserved when stall asserts (≥ upstream latency in words)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- out_data_width  in  3  3'b111 8-bit, 3'b011 4-bit, 3'b001 2-bit; other codes treated as 8-bit
- in_vld  in  1  conv output beat valid
- in_dat  in  OUT_W  lane i at [i*LANE_DW +: LANE_DW], value in low bits
- flush  in  1  end of tile; emit any partial word
- stall  out  1  FIFO occupancy ≥ FIFO_DEPTH−AFULL_MARGIN
- out_vld  out  1  FIFO head valid
- out_dat  out  OUT_W  packed word
- out_rdy  in  1  consumer accepts when out_vld&out_rdy
- ovf_err  out  1  sticky: word dropped on full FIFO
- word_cnt  out  16  words pushed since reset (wraps)

## Operation
- Width decode: dw = 8/4/2, R = LANE_DW/dw = 1/2/4 beats per word, slice = TOUT*dw bits (256/128/64).
- Beat compaction: slice bits [i*dw +: dw] = in_dat[i*LANE_DW +: dw]; upper lane bits discarded (no saturation here; upstream already clipped).
- Pack register `acc` (OUT_W) plus `pack_cnt` (0..R−1). On in_vld: write slice at acc[pack_cnt*slice +: slice]; first beat lands in lowest bits.
- If pack_cnt==R−1: push {slice, acc lower part} to FIFO, pack_cnt←0, acc←0. Else pack_cnt+1.
- flush with pack_cnt≠0 (after including a same-cycle in_vld beat): push acc zero-padded above the last slice; pack_cnt←0. flush with pack_cnt==0 (or beat just completed a word): no extra push. At most one push per cycle: if in_vld completes a word and flush arrives, only the complete word is pushed.
- out_data_width sampled every beat; changing it with pack_cnt≠0 is illegal (behaviour undefined; upstream guarantees tile boundaries flushed).
- FIFO: push and pop in same cycle allowed, including at full (pop frees slot first) and empty (no bypass; word appears next cycle).
- Push when full and no pop: word dropped, ovf_err←1 until rst. word_cnt increments per accepted push only.
- States: packing is counter-driven; FIFO has EMPTY/PARTIAL/FULL via count (0..FIFO_DEPTH).

## Timing
- Reset values: out_vld 0, out_dat 0, stall 0, ovf_err 0, word_cnt 0, pack_cnt 0, acc 0, FIFO empty. rst mid-tile discards partial word and all queued words.
- Latency: beat completing a word at cycle t (or flush at t) → out_vld=1 with that word at t+1 if FIFO was empty.
- out_dat stable and out_vld held while out_vld&!out_rdy.
- stall registered: reflects count at end of previous cycle; asserts the cycle after count reaches FIFO_DEPTH−AFULL_MARGIN, deasserts the cycle after it drops below.
- Throughput: one word in, one word out per cycle sustained at 8-bit.

## Test plan
- 8-bit, 4 beats lane value = beat index, out_rdy=1 → 4 words at t+1..t+4, each byte = 0,1,2,3; word_cnt=4.
- 4-bit, beats A (lanes 0x5) then B (lanes 0xA), lane upper nibbles 0xF → one word: low 128 bits all 0x55…, high 128 bits 0xAA…; upper nibbles absent.
- 2-bit, 3 beats of lanes 2'b01 then flush → one word: low 192 bits 0x55…, high 64 bits 0; pack_cnt=0 after.
- 4-bit, beat completing word with flush same cycle → exactly one push; flush on empty pack → no push.
- out_rdy=0, 8-bit stream of 20 beats → stall asserts after 10th word counted, FIFO holds 16, ovf_err=1, word_cnt=16; release out_rdy → 16 words in order.
- rst asserted mid-tile with 5 queued words and pack_cnt=1 → next cycle out_vld=0, word_cnt=0, ovf_err=0, subsequent packing starts at low slice.

Source files
------------

// File: rtl/conv_out_wb_packer_if.sv
// Stream bundle between the conv output stage, the packer and the DDR
// write-back master: quantized beats in, packed memory words out.
interface conv_out_wb_packer_if #(
    parameter int OUT_W = 256
) ();
    logic             in_vld;
    logic [OUT_W-1:0] in_dat;
    logic             flush;
    logic             out_vld;
    logic [OUT_W-1:0] out_dat;
    logic             out_rdy;

    // Environment side: drives conv beats, tile flush and consumer ready.
    modport master (
        output in_vld,
        output in_dat,
        output flush,
        output out_rdy,
        input  out_vld,
        input  out_dat
    );

    // Packer side.
    modport slave (
        input  in_vld,
        input  in_dat,
        input  flush,
        input  out_rdy,
        output out_vld,
        output out_dat
    );
endinterface

// File: rtl/conv_out_wb_packer.sv
// Write-back packer: compacts each lane of a conv output beat to the active
// output width, packs 1/2/4 beats into one memory word and queues the words
// for the DDR write-back master. The conv pipeline cannot be stopped, so an
// early stall flag leaves AFULL_MARGIN free entries for in-flight beats.
module conv_out_wb_packer #(
    parameter int TOUT         = 32,
    parameter int LANE_DW      = 8,
    parameter int OUT_W        = TOUT * LANE_DW,
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_MARGIN = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 out_data_width,
    conv_out_wb_packer_if.slave        bus,
    output logic                       stall,
    output logic                       ovf_err,
    output logic [15:0]                word_cnt
);

    localparam int SL4 = TOUT * 4;
    localparam int SL2 = TOUT * 2;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int SHW = $clog2(OUT_W) + 1;

    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_AFULL  = CW'(FIFO_DEPTH - AFULL_MARGIN);
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};

    typedef enum logic [1:0] {
        MODE_8 = 2'd0,
        MODE_4 = 2'd1,
        MODE_2 = 2'd2
    } mode_e;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [OUT_W-1:0] acc_r;
    logic [1:0]       pack_cnt_r;
    logic [OUT_W-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             out_vld_r;
    logic [OUT_W-1:0] out_dat_r;
    logic             stall_r;
    logic             ovf_err_r;
    logic [15:0]      word_cnt_r;

    // ---------------------------------------------------------------
    // Combinational
    // ---------------------------------------------------------------
    mode_e            mode_s;
    logic [1:0]       last_idx_s;
    logic [SHW-1:0]   shamt_s;
    logic [SL4-1:0]   c4_s;
    logic [SL2-1:0]   c2_s;
    logic [OUT_W-1:0] slice_wide_s;
    logic [OUT_W-1:0] acc_mrg_s;
    logic [OUT_W-1:0] acc_nxt_s;
    logic [1:0]       cnt_nxt_s;
    logic             push_req_s;
    logic [OUT_W-1:0] push_dat_s;
    logic             full_s;
    logic             pop_s;
    logic             push_ok_s;
    logic             drop_s;
    logic [CW-1:0]    count_nxt_s;
    logic [CW-1:0]    remain_s;
    logic [PW-1:0]    rd_ptr_inc_s;
    logic [OUT_W-1:0] head_nxt_s;

    // Decode output width: unknown codes fall back to full 8-bit lanes.
    always_comb begin
        mode_s     = MODE_8;
        last_idx_s = 2'd0;
        shamt_s    = {SHW{1'b0}};
        case (out_data_width)
            3'b011: begin
                mode_s     = MODE_4;
                last_idx_s = 2'd1;
                shamt_s    = SHW'(pack_cnt_r) * SHW'(SL4);
            end
            3'b001: begin
                mode_s     = MODE_2;
                last_idx_s = 2'd3;
                shamt_s    = SHW'(pack_cnt_r) * SHW'(SL2);
            end
            default: begin
                mode_s     = MODE_8;
                last_idx_s = 2'd0;
                shamt_s    = {SHW{1'b0}};
            end
        endcase
    end

    // Keep the low dw bits of every lane; upstream has already clipped.
    always_comb begin
        c4_s = {SL4{1'b0}};
        c2_s = {SL2{1'b0}};
        for (int i = 0; i < TOUT; i++) begin
            c4_s[i*4 +: 4] = bus.in_dat[i*LANE_DW +: 4];
            c2_s[i*2 +: 2] = bus.in_dat[i*LANE_DW +: 2];
        end
    end

    // Zero-extend the compacted slice and place it above the beats already held.
    always_comb begin
        case (mode_s)
            MODE_4:  slice_wide_s = {{(OUT_W-SL4){1'b0}}, c4_s};
            MODE_2:  slice_wide_s = {{(OUT_W-SL2){1'b0}}, c2_s};
            default: slice_wide_s = bus.in_dat;
        endcase
        if (bus.in_vld) begin
            acc_mrg_s = acc_r | (slice_wide_s << shamt_s);
        end else begin
            acc_mrg_s = acc_r;
        end
    end

    // Pack control: complete word or flush of a non-empty pack pushes once.
    always_comb begin
        push_req_s = 1'b0;
        push_dat_s = acc_mrg_s;
        acc_nxt_s  = acc_r;
        cnt_nxt_s  = pack_cnt_r;
        if (bus.in_vld) begin
            if ((pack_cnt_r >= last_idx_s) || bus.flush) begin
                push_req_s = 1'b1;
                acc_nxt_s  = {OUT_W{1'b0}};
                cnt_nxt_s  = 2'd0;
            end else begin
                acc_nxt_s  = acc_mrg_s;
                cnt_nxt_s  = pack_cnt_r + 2'd1;
            end
        end else if (bus.flush && (pack_cnt_r != 2'd0)) begin
            push_req_s = 1'b1;
            acc_nxt_s  = {OUT_W{1'b0}};
            cnt_nxt_s  = 2'd0;
        end else begin
            push_req_s = 1'b0;
        end
    end

    // FIFO bookkeeping: a pop frees its slot before a same-cycle push.
    always_comb begin
        full_s       = (count_r == CNT_FULL);
        pop_s        = out_vld_r & bus.out_rdy;
        push_ok_s    = push_req_s & (~full_s | pop_s);
        drop_s       = push_req_s & full_s & ~pop_s;
        count_nxt_s  = count_r + CW'(push_ok_s) - CW'(pop_s);
        remain_s     = count_r - CW'(pop_s);
        rd_ptr_inc_s = rd_ptr_r + PTR_ONE;
        if (count_nxt_s == CNT_ZERO) begin
            head_nxt_s = {OUT_W{1'b0}};
        end else if (remain_s == CNT_ZERO) begin
            head_nxt_s = push_dat_s;
        end else if (pop_s) begin
            head_nxt_s = mem_r[rd_ptr_inc_s];
        end else begin
            head_nxt_s = out_dat_r;
        end
    end

    // Word storage; contents are only observed through the registered head.
    always_ff @(posedge clk) begin
        if (push_ok_s && !rst) begin
            mem_r[wr_ptr_r] <= push_dat_s;
        end
    end

    // Pack registers, FIFO pointers and all registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r      <= {OUT_W{1'b0}};
            pack_cnt_r <= 2'd0;
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            out_vld_r  <= 1'b0;
            out_dat_r  <= {OUT_W{1'b0}};
            stall_r    <= 1'b0;
            ovf_err_r  <= 1'b0;
            word_cnt_r <= 16'd0;
        end else begin
            acc_r      <= acc_nxt_s;
            pack_cnt_r <= cnt_nxt_s;
            count_r    <= count_nxt_s;
            out_vld_r  <= (count_nxt_s != CNT_ZERO);
            out_dat_r  <= head_nxt_s;
            stall_r    <= (count_r >= CNT_AFULL);
            if (push_ok_s) begin
                wr_ptr_r   <= wr_ptr_r + PTR_ONE;
                word_cnt_r <= word_cnt_r + 16'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            if (drop_s) begin
                ovf_err_r <= 1'b1;
            end
        end
    end

    assign bus.out_vld = out_vld_r;
    assign bus.out_dat = out_dat_r;
    assign stall       = stall_r;
    assign ovf_err     = ovf_err_r;
    assign word_cnt    = word_cnt_r;

endmodule
